// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read port among N_MST read masters, one burst in flight.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority; the default is round-robin.
module axi_rd_arbiter #(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N_MST*ADDR_W-1:0] m_araddr,
  input  logic [N_MST*8-1:0]      m_arlen,
  input  logic [N_MST-1:0]        m_arvalid,
  output logic [N_MST-1:0]        m_arready,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_rlast,
  output logic [N_MST-1:0]        m_rvalid,
  input  logic [N_MST-1:0]        m_rready,
  output logic [ADDR_W-1:0]       s_araddr,
  output logic [7:0]              s_arlen,
  output logic [3:0]              s_arid,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [DATA_W-1:0]       s_rdata,
  input  logic                    s_rlast,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  output logic                    beat_err
);
  localparam int IW = $clog2(N_MST);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic err_q, err_d, found;
  assign beat_err = err_q;
  // Choose the requester to serve next
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = 0; k < N_MST; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      if (!found && m_arvalid[k]) begin
        pick = IW'(k);
        found = 1'b1;
      end
`else
      int j;
      j = (int'(last_q) + 1 + k) % N_MST;
      if (!found && m_arvalid[j]) begin
        pick = IW'(j);
        found = 1'b1;
      end
`endif
    end
  end
  // Next-state logic and channel routing
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    addr_d = addr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    err_d = err_q;
    m_arready = '0;
    m_rvalid = '0;
    m_rdata = '0;
    m_rlast = 1'b0;
    s_araddr = '0;
    s_arlen = '0;
    s_arid = '0;
    s_arvalid = 1'b0;
    s_rready = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        m_arready[pick] = 1'b1;
        grant_d = pick;
        addr_d = m_araddr[pick*ADDR_W +: ADDR_W];
        len_d = m_arlen[pick*8 +: 8];
        cnt_d = '0;
        state_d = ADDR;
      end
      ADDR: begin
        s_arvalid = 1'b1;
        s_araddr = addr_q;
        s_arlen = len_q;
        s_arid = 4'(grant_q);
        state_d = s_arready ? DATA : ADDR;
      end
      DATA: begin
        m_rvalid[grant_q] = s_rvalid;
        s_rready = m_rready[grant_q];
        m_rdata = s_rdata;
        m_rlast = s_rlast;
        if (s_rvalid && m_rready[grant_q]) begin
          cnt_d = cnt_q + 8'd1;
          if (s_rlast ? cnt_q != len_q : cnt_q == len_q) err_d = 1'b1;
          if (s_rlast) begin
            state_d = IDLE;
            last_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and captured-request registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= IW'(N_MST - 1);
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for axi_rd_arbiter with a reference arbitration model.
module tb_axi_rd_arbiter;
  localparam int N = 3, AW = 32, DW = 64;
  typedef struct {int id; logic [DW-1:0] d; logic l;} beat_t;
  logic aclk = 1'b0, aresetn;
  logic [N*AW-1:0] m_araddr;
  logic [N*8-1:0] m_arlen;
  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0] m_rdata, s_rdata;
  logic m_rlast, s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, beat_err;
  logic [AW-1:0] s_araddr;
  logic [7:0] s_arlen;
  logic [3:0] s_arid;
  int cmp = 0, bad = 0;
  // reference model: phase 0 idle, 1 address, 2 data
  int ph = 0, lg = N - 1, g = 0, gl = 0, nb = 0, bi = 0, nbeats = 0;
  logic [AW-1:0] ga = '0;
  bit rerr = 0;
  beat_t bq[$];
  int glog[$];
  // stimulus controls and slave model
  int want[N], ml[N], inj = -1, stall_n = 0, rlow = 0;
  bit fix_addr = 0, rgap = 0;
  logic [N-1:0] hs_m = '0;
  bit hs_ar = 0, hs_r = 0, sl_act = 0;
  logic [AW-1:0] sa = '0, sa_cap = '0;
  logic [7:0] sl_cap = '0;
  int sn = 0, sb = 0;

  axi_rd_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arid(s_arid), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready), .beat_err(beat_err)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] dfn(logic [AW-1:0] a, int b);
    return {a, 32'(b) ^ 32'h5a5a_0000};
  endfunction

  function automatic int pick(logic [N-1:0] v);
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (v[k]) return k;
`else
    for (int k = 1; k <= N; k++) if (v[(lg + k) % N]) return (lg + k) % N;
`endif
    return -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += want[i];
    return s;
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic monitor();
    int p;
    logic [N-1:0] ear, oh, eo;
    beat_t e;
    p = pick(m_arvalid);
    ear = '0;
    if (ph == 0 && p >= 0) ear[p] = 1'b1;
    oh = '0;
    oh[g] = 1'b1;
    chk("m_arready", m_arready, ear);
    chk("s_arvalid", s_arvalid, ph == 1);
    chk("s_araddr", s_araddr, ph == 1 ? ga : 0);
    chk("s_arlen", s_arlen, ph == 1 ? gl : 0);
    chk("s_arid", s_arid, ph == 1 ? g : 0);
    chk("m_rvalid", m_rvalid, (ph == 2 && s_rvalid) ? oh : '0);
    chk("s_rready", s_rready, ph == 2 && m_rready[g]);
    chk("m_rdata", m_rdata, ph == 2 ? s_rdata : '0);
    chk("m_rlast", m_rlast, ph == 2 && s_rlast);
    chk("beat_err", beat_err, rerr);
    if (aresetn && ph == 2 && s_rvalid && m_rready[g]) begin
      if (bq.size() == 0) chk("extra_beat", 1, 0);
      else begin
        e = bq.pop_front();
        eo = '0;
        eo[e.id] = 1'b1;
        chk("beat_owner", m_rvalid, eo);
        chk("beat_data", m_rdata, e.d);
        chk("beat_last", m_rlast, e.l);
        nbeats++;
      end
    end
    hs_m = m_arvalid & m_arready;
    hs_ar = s_arvalid && s_arready;
    hs_r = s_rvalid && s_rready;
    sa_cap = s_araddr;
    sl_cap = s_arlen;
    if (!aresetn) begin
      ph = 0;
      lg = N - 1;
      rerr = 0;
      bq.delete();
    end else if (ph == 0) begin
      if (p >= 0) begin
        g = p;
        ga = m_araddr[p*AW +: AW];
        gl = int'(m_arlen[p*8 +: 8]);
        bi = 0;
        ph = 1;
        glog.push_back(p);
        nb = inj >= 0 ? inj + 1 : gl + 1;
        for (int b = 0; b < nb; b++) bq.push_back('{p, dfn(ga, b), b == nb - 1});
      end
    end else if (ph == 1) begin
      if (s_arready) ph = 2;
    end else if (s_rvalid && m_rready[g]) begin
      if (s_rlast ? bi != gl : bi == gl) rerr = 1;
      bi++;
      if (s_rlast) begin
        ph = 0;
        lg = g;
      end
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    if (!aresetn) return;
    for (int i = 0; i < N; i++) begin
      if (hs_m[i]) m_arvalid[i] = 1'b0;
      if (!m_arvalid[i] && want[i] > 0 && (!rgap || $urandom % 2 == 0)) begin
        want[i]--;
        m_arvalid[i] = 1'b1;
        m_araddr[i*AW +: AW] = fix_addr ? 32'h8000_0000 : ($urandom & 32'hffff_fff8);
        m_arlen[i*8 +: 8] = ml[i] < 0 ? 8'($urandom_range(0, 7)) : 8'(ml[i]);
      end
    end
    if (stall_n > 0 && s_arvalid) begin
      s_arready = 1'b0;
      stall_n--;
    end else s_arready = rgap ? ($urandom % 3) != 0 : 1'b1;
    if (hs_ar) begin
      sl_act = 1;
      sa = sa_cap;
      sb = 0;
      sn = inj >= 0 ? inj + 1 : int'(sl_cap) + 1;
    end
    if (hs_r) begin
      s_rvalid = 1'b0;
      s_rlast = 1'b0;
      sb++;
      if (sb == sn) sl_act = 0;
    end
    if (sl_act && !s_rvalid && (!rgap || $urandom % 3 != 0)) begin
      s_rvalid = 1'b1;
      s_rdata = dfn(sa, sb);
      s_rlast = sb == sn - 1;
    end
    m_rready = rlow > 0 ? '0 : (rgap ? N'($urandom) : '1);
    if (rlow > 0 && s_rvalid) rlow--;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    m_arvalid = '0;
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    s_arready = 1'b0;
    sl_act = 0;
    stall_n = 0;
    rlow = 0;
    for (int i = 0; i < N; i++) want[i] = 0;
    step();
    chk("rst_outs", {s_araddr, s_arlen, s_arid, m_arready, m_rvalid, s_arvalid, s_rready, m_rlast, beat_err}, 0);
    chk("rst_rdata", m_rdata, 0);
    step();
    aresetn = 1'b1;
  endtask

  task automatic wait_idle(string n, int lim);
    int c = 0;
    while ((ph != 0 || sl_act || m_arvalid != '0 || pending() != 0) && c < lim) begin
      step();
      c++;
    end
    chk(n, c < lim, 1);
  endtask

  initial begin
    int n0, c;
    aresetn = 1'b0;
    m_arvalid = '0;
    m_araddr = '0;
    m_arlen = '0;
    m_rready = '1;
    s_arready = 1'b0;
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      want[i] = 0;
      ml[i] = -1;
    end
    fork
      forever begin
        @(negedge aclk);
        monitor();
      end
    join_none
    repeat (3) step();
    aresetn = 1'b1;
    // single-beat read from master 0
    fix_addr = 1;
    ml[0] = 0;
    want[0] = 1;
    n0 = nbeats;
    wait_idle("t1_done", 100);
    chk("t1_grants", glog.size(), 1);
    chk("t1_owner", glog[0], 0);
    chk("t1_beats", nbeats - n0, 1);
    chk("t1_err", beat_err, 0);
    fix_addr = 0;
    // two masters requesting continuously
    do_reset();
    glog.delete();
    ml[1] = 0;
    want[0] = 4;
    want[1] = 4;
    wait_idle("t2_done", 400);
    chk("t2_count", glog.size(), 8);
    if (glog.size() >= 4)
      for (int k = 0; k < 4; k++)
`ifdef ARB_FIXED_PRIO_EN
        chk("t2_order", glog[k], 0);
`else
        chk("t2_order", glog[k], k % 2);
`endif
    // four-beat burst with gaps and stalled rready
    glog.delete();
    n0 = nbeats;
    rgap = 1;
    rlow = 2;
    ml[1] = 3;
    want[1] = 1;
    wait_idle("t3_done", 400);
    chk("t3_beats", nbeats - n0, 4);
    chk("t3_owner", glog[0], 1);
    chk("t3_rlow", rlow, 0);
    rgap = 0;
    // early rlast sets a sticky error
    n0 = nbeats;
    inj = 1;
    ml[0] = 3;
    want[0] = 1;
    wait_idle("t4_done", 200);
    chk("t4_err", beat_err, 1);
    chk("t4_beats", nbeats - n0, 2);
    inj = -1;
    ml[0] = 1;
    want[0] = 1;
    wait_idle("t4_done2", 200);
    chk("t4_sticky", beat_err, 1);
    // missing rlast at arlen also flags, forwarding continues
    do_reset();
    chk("t4b_clr", beat_err, 0);
    n0 = nbeats;
    inj = 4;
    ml[2] = 2;
    want[2] = 1;
    wait_idle("t4b_done", 200);
    chk("t4b_err", beat_err, 1);
    chk("t4b_beats", nbeats - n0, 5);
    inj = -1;
    // reset in the middle of a long burst
    do_reset();
    ml[0] = 0;
    want[0] = 1;
    wait_idle("t5_pre", 100);
    rgap = 1;
    ml[1] = 7;
    want[1] = 1;
    c = 0;
    while (!(ph == 2 && bi >= 2) && c < 300) begin
      step();
      c++;
    end
    chk("t5_reach", c < 300, 1);
    do_reset();
    rgap = 0;
    glog.delete();
    ml[0] = 0;
    ml[1] = 0;
    want[0] = 1;
    want[1] = 1;
    wait_idle("t5_done", 200);
    chk("t5_first", glog[0], 0);
    // slave holds s_arready low in ADDR
    glog.delete();
    stall_n = 5;
    ml[2] = 1;
    want[2] = 1;
    wait_idle("t6_done", 200);
    chk("t6_stall", stall_n, 0);
    chk("t6_owner", glog[0], 2);
    // randomized traffic from all masters
    rgap = 1;
    for (int i = 0; i < N; i++) begin
      ml[i] = -1;
      want[i] = 12;
    end
    wait_idle("rand_done", 8000);
    chk("rand_queue", bq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
